jtag_tap_ctrl: RTL

//  IEEE 1149.1 TAP controller and instruction register for the 180-voltmeter test port.

---
 rtl/jtag_tap_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller with instruction register, IDCODE and BYPASS registers,
// DR-phase strobes, instruction selects and the TDO output mux.
module jtag_tap_ctrl #(
  parameter int          IR_LEN     = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1180_0001
) (
  input  logic tck_i,
  input  logic test_logic_reset_i,
  input  logic tms_i,
  input  logic tdi_i,
  output logic tdo_o,
  output logic tdo_oe_o,
  output logic tlr_o,
  output logic capture_dr_o,
  output logic shift_dr_o,
  output logic pause_dr_o,
  output logic update_dr_o,
  output logic extest_select_o,
  output logic sample_preload_select_o,
  output logic mbist_select_o,
  output logic debug_select_o,
  output logic tdi_o,
  input  logic bs_chain_so_i,
  input  logic debug_so_i,
  input  logic mbist_so_i
);

  // One-hot encoding: each DR strobe is a single flop bit, so it cannot glitch.
  typedef enum logic [15:0] {
    S_TLR     = 16'h0001,
    S_RTI     = 16'h0002,
    S_SELDR   = 16'h0004,
    S_CAPDR   = 16'h0008,
    S_SHIFTDR = 16'h0010,
    S_EXIT1DR = 16'h0020,
    S_PAUSEDR = 16'h0040,
    S_EXIT2DR = 16'h0080,
    S_UPDDR   = 16'h0100,
    S_SELIR   = 16'h0200,
    S_CAPIR   = 16'h0400,
    S_SHIFTIR = 16'h0800,
    S_EXIT1IR = 16'h1000,
    S_PAUSEIR = 16'h2000,
    S_EXIT2IR = 16'h4000,
    S_UPDIR   = 16'h8000
  } tap_state_e;

  localparam logic [IR_LEN-1:0] IR_EXTEST  = IR_LEN'(4'h0);
  localparam logic [IR_LEN-1:0] IR_SAMPLE  = IR_LEN'(4'h1);
  localparam logic [IR_LEN-1:0] IR_IDCODE  = IR_LEN'(4'h2);
  localparam logic [IR_LEN-1:0] IR_DEBUG   = IR_LEN'(4'h8);
  localparam logic [IR_LEN-1:0] IR_MBIST   = IR_LEN'(4'h9);
  localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(4'h1);

  tap_state_e        r_state;
  tap_state_e        w_next_state;
  logic              r_tlr;
  logic [IR_LEN-1:0] r_ir_shift;
  logic [IR_LEN-1:0] r_ir_active;
  logic [31:0]       r_idcode;
  logic              r_bypass;
  logic              r_tdo;
  logic              r_tdo_oe;
  logic              w_dr_so;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state = S_TLR;
    case (r_state)
      S_TLR:     w_next_state = tms_i ? S_TLR     : S_RTI;
      S_RTI:     w_next_state = tms_i ? S_SELDR   : S_RTI;
      S_SELDR:   w_next_state = tms_i ? S_SELIR   : S_CAPDR;
      S_CAPDR:   w_next_state = tms_i ? S_EXIT1DR : S_SHIFTDR;
      S_SHIFTDR: w_next_state = tms_i ? S_EXIT1DR : S_SHIFTDR;
      S_EXIT1DR: w_next_state = tms_i ? S_UPDDR   : S_PAUSEDR;
      S_PAUSEDR: w_next_state = tms_i ? S_EXIT2DR : S_PAUSEDR;
      S_EXIT2DR: w_next_state = tms_i ? S_UPDDR   : S_SHIFTDR;
      S_UPDDR:   w_next_state = tms_i ? S_SELDR   : S_RTI;
      S_SELIR:   w_next_state = tms_i ? S_TLR     : S_CAPIR;
      S_CAPIR:   w_next_state = tms_i ? S_EXIT1IR : S_SHIFTIR;
      S_SHIFTIR: w_next_state = tms_i ? S_EXIT1IR : S_SHIFTIR;
      S_EXIT1IR: w_next_state = tms_i ? S_UPDIR   : S_PAUSEIR;
      S_PAUSEIR: w_next_state = tms_i ? S_EXIT2IR : S_PAUSEIR;
      S_EXIT2IR: w_next_state = tms_i ? S_UPDIR   : S_SHIFTIR;
      S_UPDIR:   w_next_state = tms_i ? S_SELDR   : S_RTI;
      default:   w_next_state = S_TLR;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge tck_i or posedge test_logic_reset_i) begin
    if (test_logic_reset_i) begin
      r_state <= S_TLR;
      r_tlr   <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_tlr   <= (w_next_state == S_TLR);
    end
  end

  // Forcing IDCODE on entry to TLR keeps it loaded for the whole stay in TLR.
  always_ff @(posedge tck_i or posedge test_logic_reset_i) begin
    if (test_logic_reset_i) begin
      r_ir_shift  <= IR_CAPTURE;
      r_ir_active <= IR_IDCODE;
    end else begin
      if (r_state == S_CAPIR)        r_ir_shift <= IR_CAPTURE;
      else if (r_state == S_SHIFTIR) r_ir_shift <= {tdi_i, r_ir_shift[IR_LEN-1:1]};

      if (w_next_state == S_TLR)     r_ir_active <= IR_IDCODE;
      else if (r_state == S_UPDIR)   r_ir_active <= r_ir_shift;
    end
  end

  // NOTE: only these few control/data flops take the async reset; there are no memories here.
  always_ff @(posedge tck_i or posedge test_logic_reset_i) begin
    if (test_logic_reset_i) begin
      r_idcode <= IDCODE_VAL;
      r_bypass <= 1'b0;
    end else if (r_state == S_CAPDR) begin
      r_idcode <= IDCODE_VAL;
      r_bypass <= 1'b0;
    end else if (r_state == S_SHIFTDR) begin
      r_bypass <= tdi_i;
      if (r_ir_active == IR_IDCODE) r_idcode <= {tdi_i, r_idcode[31:1]};
    end
  end

  always_comb begin
    w_dr_so = r_bypass;
    case (r_ir_active)
      IR_EXTEST, IR_SAMPLE: w_dr_so = bs_chain_so_i;
      IR_IDCODE:            w_dr_so = r_idcode[0];
      IR_DEBUG:             w_dr_so = debug_so_i;
      IR_MBIST:             w_dr_so = mbist_so_i;
      default:              w_dr_so = r_bypass;
    endcase
  end

  // TDO changes on the falling edge so the tester samples it cleanly on the next rise.
  always_ff @(negedge tck_i or posedge test_logic_reset_i) begin
    if (test_logic_reset_i) begin
      r_tdo    <= 1'b0;
      r_tdo_oe <= 1'b0;
    end else begin
      r_tdo_oe <= (r_state == S_SHIFTDR) || (r_state == S_SHIFTIR);
      if (r_state == S_SHIFTIR)      r_tdo <= r_ir_shift[0];
      else if (r_state == S_SHIFTDR) r_tdo <= w_dr_so;
      else                           r_tdo <= 1'b0;
    end
  end

  assign tdo_o                   = r_tdo;
  assign tdo_oe_o                = r_tdo_oe;
  assign tlr_o                   = r_tlr;
  assign capture_dr_o            = r_state[3];
  assign shift_dr_o              = r_state[4];
  assign pause_dr_o              = r_state[6];
  assign update_dr_o             = r_state[8];
  assign extest_select_o         = (r_ir_active == IR_EXTEST);
  assign sample_preload_select_o = (r_ir_active == IR_SAMPLE);
  assign mbist_select_o          = (r_ir_active == IR_MBIST);
  assign debug_select_o          = (r_ir_active == IR_DEBUG);
  assign tdi_o                   = tdi_i;

endmodule
